// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state encoding and opcodes for the SPI RAM master
package spi_pkg;

    typedef enum logic [2:0] {
        M_IDLE,
        M_START,
        M_SHIFT,
        M_RD_WAIT,
        M_RD_CAPT,
        M_GAP
    } master_state_e;

    localparam logic [2:0] OP_WR_ADDR = 3'b000;
    localparam logic [2:0] OP_WR_DATA = 3'b001;
    localparam logic [2:0] OP_RD_ADDR = 3'b110;
    localparam logic [2:0] OP_RD_DATA = 3'b111;

endpackage

// File: rtl/spi_ram_master.sv
// rtl/spi_ram_master.sv - host-side SPI master expanding word requests into two slave frames
module spi_ram_master
    import spi_pkg::*;
#(
    parameter int ADDR_SIZE  = 8,
    parameter int RD_LAT     = 2,
    parameter int GAP_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_wr,
    input  logic [ADDR_SIZE-1:0] req_addr,
    input  logic [ADDR_SIZE-1:0] req_wdata,
    output logic                 rsp_valid,
    output logic [ADDR_SIZE-1:0] rsp_rdata,
    output logic                 busy,
    output logic                 SS_n,
    output logic                 MOSI,
    input  logic                 MISO
);

    localparam int FW   = ADDR_SIZE + 3;
    localparam int CW   = $clog2(FW);
    localparam int WMAX = (RD_LAT > GAP_CYCLES) ? RD_LAT : GAP_CYCLES;
    localparam int WW   = $clog2(WMAX + 1);

    master_state_e          state_q, state_d;
    logic                   frame_idx_q, frame_idx_d;
    logic                   is_wr_q, is_wr_d;
    logic [ADDR_SIZE-1:0]   wdata_q, wdata_d;
    logic [FW-1:0]          frame_q, frame_d;
    logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [WW-1:0]          wait_cnt_q, wait_cnt_d;
    // The eighth captured bit goes straight into rsp_rdata, so only seven are staged here.
    logic [ADDR_SIZE-2:0]   cap_q, cap_d;
    logic [ADDR_SIZE-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic                   req_ready_q, req_ready_d;
    logic                   busy_q, busy_d;
    logic                   ss_n_q, ss_n_d;
    logic                   mosi_q, mosi_d;

    // Next-state and datapath; outputs are precomputed from the next state so they register cleanly.
    always_comb begin
        state_d     = state_q;
        frame_idx_d = frame_idx_q;
        is_wr_d     = is_wr_q;
        wdata_d     = wdata_q;
        frame_d     = frame_q;
        bit_cnt_d   = bit_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        cap_d       = cap_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_valid_d = 1'b0;

        case (state_q)
            M_IDLE: begin
                if (req_valid && req_ready_q) begin
                    state_d     = M_START;
                    frame_idx_d = 1'b0;
                    is_wr_d     = req_wr;
                    wdata_d     = req_wr ? req_wdata : '0;
                    frame_d     = {(req_wr ? OP_WR_ADDR : OP_RD_ADDR), req_addr};
                end
            end
            M_START: begin
                state_d   = M_SHIFT;
                bit_cnt_d = CW'(FW - 1);
            end
            M_SHIFT: begin
                if (bit_cnt_q == '0) begin
                    if (!is_wr_q && frame_idx_q) begin
                        state_d    = M_RD_WAIT;
                        wait_cnt_d = WW'(RD_LAT - 1);
                    end else begin
                        state_d    = M_GAP;
                        wait_cnt_d = WW'(GAP_CYCLES - 1);
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end
            end
            M_RD_WAIT: begin
                if (wait_cnt_q == '0) begin
                    state_d   = M_RD_CAPT;
                    bit_cnt_d = CW'(ADDR_SIZE - 1);
                end else begin
                    wait_cnt_d = wait_cnt_q - 1'b1;
                end
            end
            M_RD_CAPT: begin
                cap_d = {cap_q[ADDR_SIZE-3:0], MISO};
                if (bit_cnt_q == '0) begin
                    rsp_rdata_d = {cap_q, MISO};
                    rsp_valid_d = 1'b1;
                    state_d     = M_GAP;
                    wait_cnt_d  = WW'(GAP_CYCLES - 1);
                end else begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end
            end
            M_GAP: begin
                if (wait_cnt_q == '0) begin
                    if (!frame_idx_q) begin
                        frame_idx_d = 1'b1;
                        state_d     = M_START;
                        frame_d     = {(is_wr_q ? OP_WR_DATA : OP_RD_DATA), wdata_q};
                    end else begin
                        state_d = M_IDLE;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q - 1'b1;
                end
            end
            default: state_d = M_IDLE;
        endcase

        req_ready_d = (state_d == M_IDLE);
        busy_d      = (state_d != M_IDLE);
        ss_n_d      = (state_d == M_IDLE) || (state_d == M_GAP);
        mosi_d      = (state_d == M_SHIFT) ? frame_d[bit_cnt_d] : 1'b0;
    end

    // State and output registers; reset drops SS_n high at once, abandoning any frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= M_IDLE;
            frame_idx_q <= 1'b0;
            is_wr_q     <= 1'b0;
            wdata_q     <= '0;
            frame_q     <= '0;
            bit_cnt_q   <= '0;
            wait_cnt_q  <= '0;
            cap_q       <= '0;
            rsp_rdata_q <= '0;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            ss_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_idx_q <= frame_idx_d;
            is_wr_q     <= is_wr_d;
            wdata_q     <= wdata_d;
            frame_q     <= frame_d;
            bit_cnt_q   <= bit_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            cap_q       <= cap_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_valid_q <= rsp_valid_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            ss_n_q      <= ss_n_d;
            mosi_q      <= mosi_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign busy      = busy_q;
    assign SS_n      = ss_n_q;
    assign MOSI      = mosi_q;

endmodule
